mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
- Multi-cycle MIPS control unit; the producer side of the datapath control interface (ALU_Control, ALUSrc_B, RegWrite, DatatoReg, Branch, Jal, RegDst).
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handshakes with memory/IO via MIO_ready.
- Sits between the instruction register and the multi-cycle datapath inside the extended CPU.

Parameters:
- ST_W, 4, width of state register and state_out.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- OPcode  in  6  IR[31:26].
- Fun  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- MIO_ready  in  1  memory/IO access complete.
- ALU_Control  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt.
- ALUSrc_A  out  1  0 = PC, 1 = rs.
- ALUSrc_B  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- RegWrite  out  1  register file write enable.
- DatatoReg  out  2  00 ALU, 01 memory data, 10 PC (link).
- Branch  out  2  00 none, 01 beq, 10 bne.
- Jal  out  1  write $31 / jump target select.
- RegDst  out  1  1 = rd, 0 = rt.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IorD  out  1  0 = PC address, 1 = ALU address.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  unconditional PC write.
- PCWriteCond  out  1  conditional PC write.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- CPU_MIO  out  1  memory/IO access in progress.
- state_out  out  4  current state for debug display.

Behaviour:
- States: IF=0, ID=1, MADDR=2, MRD=3, LWWB=4, MWR=5, REX=6, RWB=7, BEQ=8, J=9, IEX=10, IWB=11, JAL=12. Codes 13-15 are unused and return to IF on the next clock.
- Outputs are a Moore decode of state, with OPcode/Fun used for ALU_Control in REX/IEX. Every output not listed for a state is 0.
- rst low: state=IF immediately. PCWrite, IRWrite, RegWrite and MemWrite are forced 0 for as long as rst is low.
- Reset mid-instruction aborts it; no partial register or memory write occurs after the reset edge.
- IF: MemRead=1, IorD=0, CPU_MIO=1, ALUSrc_A=0, ALUSrc_B=01, ALU_Control=010, PCSource=00.
  - IRWrite=PCWrite=MIO_ready.
  - Stays in IF while MIO_ready=0; goes to ID on the first edge with MIO_ready=1.
- ID: ALUSrc_A=0, ALUSrc_B=11, ALU_Control=010. Next state by OPcode:
  - 100011 or 101011 -> MADDR
  - 000000 -> REX
  - 000100 or 000101 -> BEQ
  - 000010 -> J
  - 000011 -> JAL
  - 001000, 001100, 001101, 001010 -> IEX
  - any other opcode -> IF, with no write.
- MADDR: ALUSrc_A=1, ALUSrc_B=10, ALU_Control=010. Next state MRD if lw, MWR if sw.
- MRD: MemRead=1, IorD=1, CPU_MIO=1. Waits on MIO_ready, then -> LWWB.
- LWWB: RegWrite=1, DatatoReg=01, RegDst=0. -> IF.
- MWR: MemWrite=1, IorD=1, CPU_MIO=1. Holds until MIO_ready=1, then -> IF.
- REX: ALUSrc_A=1, ALUSrc_B=00.
  - Fun mapping: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
  - Any other Fun -> IF, with no writeback.
- RWB: RegWrite=1, RegDst=1, DatatoReg=00. -> IF.
- BEQ: ALUSrc_A=1, ALUSrc_B=00, ALU_Control=110, PCWriteCond=1, PCSource=01.
  - Branch=01 for beq, 10 for bne; the datapath qualifies the PC write with zero.
  - -> IF.
- J: PCWrite=1, PCSource=10. -> IF.
- JAL: PCWrite=1, PCSource=10, Jal=1, RegWrite=1, DatatoReg=10. -> IF.
- IEX: ALUSrc_A=1, ALUSrc_B=10.
  - ALU_Control: addi 010, andi 000, ori 001, slti 111.
  - -> IWB.
- IWB: RegWrite=1, RegDst=0, DatatoReg=00. -> IF.
- Cycle counts with MIO_ready held at 1: R-type 4, lw 5, sw 4, beq/bne 3, j/jal 3, I-type 4.
- Each MIO_ready=0 cycle in IF, MRD or MWR adds exactly one cycle.

Test Plan:
- Reset: rst=0 for 2 clocks mid-MRD -> state_out=0 immediately, MemWrite/RegWrite/PCWrite=0; after release the first IF completes when MIO_ready=1.
- add (OP 000000, Fun 100000), MIO_ready=1 -> states 0,1,6,7. In REX ALU_Control=010; in RWB RegWrite=1, RegDst=1; back to 0 after 4 clocks.
- lw (100011) with MIO_ready low for 2 cycles in MRD -> states 0,1,2,3,3,3,4,0. DatatoReg=01 and RegWrite=1 only in state 4.
- beq (000100), zero=1, then bne (000101) -> state 8 shows Branch=01 then 10, PCWriteCond=1, ALU_Control=110, PCSource=01.
- jal (000011) -> state 12 with Jal=1, RegWrite=1, DatatoReg=10, PCSource=10, PCWrite=1.
- Illegal OPcode 111111, then R-type with Fun 000000 -> ID->IF and REX->IF, with no RegWrite/MemWrite pulse in either.

Source files
------------

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: multi-cycle MIPS control unit.
// Walks each instruction through fetch, decode, execute, memory and writeback
// states and drives the datapath control lines as a Moore decode of the state.
// ALU_Control additionally decodes Fun in REX and OPcode in IEX.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   OPcode, Fun              IR[31:26], IR[5:0]
//   zero                     ALU zero flag (branch qualification is done in the datapath)
//   MIO_ready                memory/IO access complete
//   ALU_Control ... PCSource datapath control outputs
//   CPU_MIO                  memory/IO access in progress
//   state_out                current state, for debug display
module mc_ctrl_unit #(
    parameter int unsigned ST_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      OPcode,
    input  logic [5:0]      Fun,
    input  logic            zero,
    input  logic            MIO_ready,
    output logic [2:0]      ALU_Control,
    output logic            ALUSrc_A,
    output logic [1:0]      ALUSrc_B,
    output logic            RegWrite,
    output logic [1:0]      DatatoReg,
    output logic [1:0]      Branch,
    output logic            Jal,
    output logic            RegDst,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [1:0]      PCSource,
    output logic            CPU_MIO,
    output logic [ST_W-1:0] state_out
);

    typedef enum logic [ST_W-1:0] {
        StIf    = ST_W'(0),
        StId    = ST_W'(1),
        StMaddr = ST_W'(2),
        StMrd   = ST_W'(3),
        StLwwb  = ST_W'(4),
        StMwr   = ST_W'(5),
        StRex   = ST_W'(6),
        StRwb   = ST_W'(7),
        StBeq   = ST_W'(8),
        StJ     = ST_W'(9),
        StIex   = ST_W'(10),
        StIwb   = ST_W'(11),
        StJal   = ST_W'(12)
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;

    state_e     state_q;
    logic [2:0] rex_alu;
    logic       rex_ok;
    logic [2:0] iex_alu;

    // The datapath ANDs PCWriteCond/Branch with zero itself.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        rex_alu = 3'b000;
        rex_ok  = 1'b1;
        case (Fun)
            6'b100000: rex_alu = 3'b010;
            6'b100010: rex_alu = 3'b110;
            6'b100100: rex_alu = 3'b000;
            6'b100101: rex_alu = 3'b001;
            6'b101010: rex_alu = 3'b111;
            default:   rex_ok  = 1'b0;
        endcase
    end

    always_comb begin
        iex_alu = 3'b010;
        case (OPcode)
            OpAndi:  iex_alu = 3'b000;
            OpOri:   iex_alu = 3'b001;
            OpSlti:  iex_alu = 3'b111;
            default: iex_alu = 3'b010;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIf;
        end else begin
            case (state_q)
                StIf:    if (MIO_ready) state_q <= StId;
                StId: begin
                    case (OPcode)
                        OpLw, OpSw:                     state_q <= StMaddr;
                        OpRtype:                        state_q <= StRex;
                        OpBeq, OpBne:                   state_q <= StBeq;
                        OpJ:                            state_q <= StJ;
                        OpJal:                          state_q <= StJal;
                        OpAddi, OpAndi, OpOri, OpSlti:  state_q <= StIex;
                        default:                        state_q <= StIf;
                    endcase
                end
                StMaddr: state_q <= (OPcode == OpLw) ? StMrd :
                                    (OPcode == OpSw) ? StMwr : StIf;
                StMrd:   if (MIO_ready) state_q <= StLwwb;
                StMwr:   if (MIO_ready) state_q <= StIf;
                // Unknown Fun aborts without writeback.
                StRex:   state_q <= rex_ok ? StRwb : StIf;
                StIex:   state_q <= StIwb;
                default: state_q <= StIf;
            endcase
        end
    end

    always_comb begin
        ALU_Control = 3'b000;
        ALUSrc_A    = 1'b0;
        ALUSrc_B    = 2'b00;
        RegWrite    = 1'b0;
        DatatoReg   = 2'b00;
        Branch      = 2'b00;
        Jal         = 1'b0;
        RegDst      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        CPU_MIO     = 1'b0;
        case (state_q)
            StIf: begin
                MemRead     = 1'b1;
                CPU_MIO     = 1'b1;
                ALUSrc_B    = 2'b01;
                ALU_Control = 3'b010;
                IRWrite     = MIO_ready;
                PCWrite     = MIO_ready;
            end
            StId: begin
                ALUSrc_B    = 2'b11;
                ALU_Control = 3'b010;
            end
            StMaddr: begin
                ALUSrc_A    = 1'b1;
                ALUSrc_B    = 2'b10;
                ALU_Control = 3'b010;
            end
            StMrd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                CPU_MIO = 1'b1;
            end
            StLwwb: begin
                RegWrite  = 1'b1;
                DatatoReg = 2'b01;
            end
            StMwr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                CPU_MIO  = 1'b1;
            end
            StRex: begin
                ALUSrc_A    = 1'b1;
                ALU_Control = rex_alu;
            end
            StRwb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            StBeq: begin
                ALUSrc_A    = 1'b1;
                ALU_Control = 3'b110;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Branch      = (OPcode == OpBne) ? 2'b10 : 2'b01;
            end
            StJ: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            StJal: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b10;
                Jal       = 1'b1;
                RegWrite  = 1'b1;
                DatatoReg = 2'b10;
            end
            StIex: begin
                ALUSrc_A    = 1'b1;
                ALUSrc_B    = 2'b10;
                ALU_Control = iex_alu;
            end
            StIwb: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
        // Architectural writes are blocked combinationally while reset is held.
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
module tb_mc_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OPcode;
    logic [5:0] Fun;
    logic       zero;
    logic       MIO_ready;
    logic [2:0] ALU_Control;
    logic       ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic       RegWrite;
    logic [1:0] DatatoReg;
    logic [1:0] Branch;
    logic       Jal;
    logic       RegDst;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] PCSource;
    logic       CPU_MIO;
    logic [3:0] state_out;

    mc_ctrl_unit #(.ST_W(4)) dut (
        .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero),
        .MIO_ready(MIO_ready), .ALU_Control(ALU_Control), .ALUSrc_A(ALUSrc_A),
        .ALUSrc_B(ALUSrc_B), .RegWrite(RegWrite), .DatatoReg(DatatoReg), .Branch(Branch),
        .Jal(Jal), .RegDst(RegDst), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .CPU_MIO(CPU_MIO), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // {ALU_Control, ALUSrc_A, ALUSrc_B, RegWrite, DatatoReg, Branch, Jal, RegDst, MemRead,
    //  MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, CPU_MIO}
    logic [21:0] ctl;
    assign ctl = {ALU_Control, ALUSrc_A, ALUSrc_B, RegWrite, DatatoReg, Branch, Jal, RegDst,
                  MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource, CPU_MIO};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fun;
        logic        mio;
        logic [3:0]  st;
        logic [21:0] c;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [21:0] pk(
        input logic [2:0] alu, input logic a, input logic [1:0] b, input logic rw,
        input logic [1:0] d2r, input logic [1:0] br, input logic jal, input logic rd,
        input logic mr, input logic mw, input logic iord, input logic irw, input logic pcw,
        input logic pcwc, input logic [1:0] pcs, input logic cpu);
        return {alu, a, b, rw, d2r, br, jal, rd, mr, mw, iord, irw, pcw, pcwc, pcs, cpu};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fun, input logic mio,
                       input logic [3:0] st, input logic [21:0] c);
        vec_t v;
        v.op = op; v.fun = fun; v.mio = mio; v.st = st; v.c = c;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, check the Moore outputs, then take the clock edge.
    task automatic apply(input string tag, input logic [5:0] op, input logic [5:0] fun,
                         input logic mio, input logic [3:0] st, input logic [21:0] c);
        OPcode = op; Fun = fun; MIO_ready = mio;
        #1;
        n_vec++;
        if (state_out !== st || ctl !== c) begin
            n_bad++;
            $display("FAIL %s: got state %0d ctl %h, want state %0d ctl %h",
                     tag, state_out, ctl, st, c);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    initial begin
        logic [21:0] x_if1, x_if0, x_id, x_maddr, x_mrd, x_lwwb, x_mwr, x_rwb, x_j, x_jal,
                     x_iwb;
        logic [5:0]  op_r, op_lw, op_sw;

        x_if1   = pk(3'b010, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 1, 1, 0, 2'b00, 1);
        x_if0   = pk(3'b010, 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        x_id    = pk(3'b010, 0, 2'b11, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        x_maddr = pk(3'b010, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        x_mrd   = pk(3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1);
        x_lwwb  = pk(3'b000, 0, 2'b00, 1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        x_mwr   = pk(3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 1);
        x_rwb   = pk(3'b000, 0, 2'b00, 1, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        x_j     = pk(3'b000, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0);
        x_jal   = pk(3'b000, 0, 2'b00, 1, 2'b10, 2'b00, 1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0);
        x_iwb   = pk(3'b000, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        op_r = 6'b000000; op_lw = 6'b100011; op_sw = 6'b101011;

        // Fetch stall, then add
        add(op_r, 6'b100000, 0, 0, x_if0);
        add(op_r, 6'b100000, 1, 0, x_if1);
        add(op_r, 6'b100000, 1, 1, x_id);
        add(op_r, 6'b100000, 1, 6, pk(3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(op_r, 6'b100000, 1, 7, x_rwb);
        // lw with two wait cycles in MRD
        add(op_lw, 6'b0, 1, 0, x_if1);
        add(op_lw, 6'b0, 1, 1, x_id);
        add(op_lw, 6'b0, 1, 2, x_maddr);
        add(op_lw, 6'b0, 0, 3, x_mrd);
        add(op_lw, 6'b0, 0, 3, x_mrd);
        add(op_lw, 6'b0, 1, 3, x_mrd);
        add(op_lw, 6'b0, 1, 4, x_lwwb);
        // sw with one wait cycle in MWR
        add(op_sw, 6'b0, 1, 0, x_if1);
        add(op_sw, 6'b0, 1, 1, x_id);
        add(op_sw, 6'b0, 1, 2, x_maddr);
        add(op_sw, 6'b0, 0, 5, x_mwr);
        add(op_sw, 6'b0, 1, 5, x_mwr);
        // sub and slt
        add(op_r, 6'b100010, 1, 0, x_if1);
        add(op_r, 6'b100010, 1, 1, x_id);
        add(op_r, 6'b100010, 1, 6, pk(3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(op_r, 6'b100010, 1, 7, x_rwb);
        add(op_r, 6'b101010, 1, 0, x_if1);
        add(op_r, 6'b101010, 1, 1, x_id);
        add(op_r, 6'b101010, 1, 6, pk(3'b111, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(op_r, 6'b101010, 1, 7, x_rwb);
        add(op_r, 6'b100101, 1, 0, x_if1);
        add(op_r, 6'b100101, 1, 1, x_id);
        add(op_r, 6'b100101, 1, 6, pk(3'b001, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(op_r, 6'b100101, 1, 7, x_rwb);
        // beq then bne
        add(6'b000100, 6'b0, 1, 0, x_if1);
        add(6'b000100, 6'b0, 1, 1, x_id);
        add(6'b000100, 6'b0, 1, 8, pk(3'b110, 1, 2'b00, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0));
        add(6'b000101, 6'b0, 1, 0, x_if1);
        add(6'b000101, 6'b0, 1, 1, x_id);
        add(6'b000101, 6'b0, 1, 8, pk(3'b110, 1, 2'b00, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0));
        // j, jal
        add(6'b000010, 6'b0, 1, 0, x_if1);
        add(6'b000010, 6'b0, 1, 1, x_id);
        add(6'b000010, 6'b0, 1, 9, x_j);
        add(6'b000011, 6'b0, 1, 0, x_if1);
        add(6'b000011, 6'b0, 1, 1, x_id);
        add(6'b000011, 6'b0, 1, 12, x_jal);
        // addi, andi, ori, slti
        add(6'b001000, 6'b0, 1, 0, x_if1);
        add(6'b001000, 6'b0, 1, 1, x_id);
        add(6'b001000, 6'b0, 1, 10, pk(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(6'b001000, 6'b0, 1, 11, x_iwb);
        add(6'b001100, 6'b0, 1, 0, x_if1);
        add(6'b001100, 6'b0, 1, 1, x_id);
        add(6'b001100, 6'b0, 1, 10, pk(3'b000, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(6'b001100, 6'b0, 1, 11, x_iwb);
        add(6'b001101, 6'b0, 1, 0, x_if1);
        add(6'b001101, 6'b0, 1, 1, x_id);
        add(6'b001101, 6'b0, 1, 10, pk(3'b001, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(6'b001101, 6'b0, 1, 11, x_iwb);
        add(6'b001010, 6'b0, 1, 0, x_if1);
        add(6'b001010, 6'b0, 1, 1, x_id);
        add(6'b001010, 6'b0, 1, 10, pk(3'b111, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(6'b001010, 6'b0, 1, 11, x_iwb);
        // Illegal opcode: ID -> IF; unknown Fun: REX -> IF
        add(6'b111111, 6'b0, 1, 0, x_if1);
        add(6'b111111, 6'b0, 1, 1, x_id);
        add(op_r, 6'b000000, 1, 0, x_if1);
        add(op_r, 6'b000000, 1, 1, x_id);
        add(op_r, 6'b000000, 1, 6, pk(3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(op_r, 6'b000000, 0, 0, x_if0);

        // Reset state
        rst = 1'b0; OPcode = '0; Fun = '0; zero = 1'b1; MIO_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("reset_state", 8'(state_out), 8'd0);
        chk("reset_writes", 8'({PCWrite, IRWrite, RegWrite, MemWrite}), 8'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].fun, vecs[i].mio,
                  vecs[i].st, vecs[i].c);

        // Reset held two clocks in the middle of MRD
        apply("rmrd_if", op_lw, 6'b0, 1, 0, x_if1);
        apply("rmrd_id", op_lw, 6'b0, 1, 1, x_id);
        apply("rmrd_ma", op_lw, 6'b0, 1, 2, x_maddr);
        apply("rmrd_mrd", op_lw, 6'b0, 0, 3, x_mrd);
        rst = 1'b0; MIO_ready = 1'b1;
        #1;
        chk("rmrd_state_now", 8'(state_out), 8'd0);
        chk("rmrd_writes_now", 8'({PCWrite, IRWrite, RegWrite, MemWrite}), 8'd0);
        @(negedge clk);
        chk("rmrd_state_c1", 8'(state_out), 8'd0);
        @(negedge clk);
        chk("rmrd_writes_c2", 8'({PCWrite, IRWrite, RegWrite, MemWrite}), 8'd0);
        rst = 1'b1;
        apply("rmrd_rel_if0", op_r, 6'b100000, 0, 0, x_if0);
        apply("rmrd_rel_if1", op_r, 6'b100000, 1, 0, x_if1);
        apply("rmrd_rel_id", op_r, 6'b100000, 1, 1, x_id);

        // Reset during MWR and RWB cuts the write strobes at once
        apply("rmwr_rex", op_r, 6'b100000, 1, 6,
              pk(3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0; #1;
        chk("rrwb_state", 8'(state_out), 8'd0);
        chk("rrwb_regwrite", 8'(RegWrite), 8'd0);
        @(negedge clk); rst = 1'b1;
        apply("rmwr_if", op_sw, 6'b0, 1, 0, x_if1);
        apply("rmwr_id", op_sw, 6'b0, 1, 1, x_id);
        apply("rmwr_ma", op_sw, 6'b0, 1, 2, x_maddr);
        apply("rmwr_mwr", op_sw, 6'b0, 0, 5, x_mwr);
        rst = 1'b0; #1;
        chk("rmwr_state", 8'(state_out), 8'd0);
        chk("rmwr_memwrite", 8'(MemWrite), 8'd0);
        @(negedge clk); rst = 1'b1;
        apply("rmwr_after", op_sw, 6'b0, 1, 0, x_if1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
